// File: rtl/ifu_pkg.sv
// -----------------------------------------------------------------------------
// ifu_pkg
//   Shared definitions for the instruction fetch unit.
//   - state_e          : fetch FSM state encoding (3 bits)
//   - RESP_OKAY        : AXI read response value that means "no error"
//   - RESET_PC_DEFAULT : default fetch address after reset
//   - is_misaligned()  : true when an instruction address is not word aligned
// -----------------------------------------------------------------------------
package ifu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,  // waiting for the first clock after reset release
    ST_REQ  = 3'd1,  // read address presented on AR
    ST_WAIT = 3'd2,  // waiting for the read data beat
    ST_HOLD = 3'd3,  // instruction presented to the core
    ST_DROP = 3'd4   // draining a read that a flush made stale
  } state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // RV32 instructions are word aligned; only the two low address bits matter.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage : ifu_pkg

// File: rtl/ifu_axi_fetch.sv
// -----------------------------------------------------------------------------
// ifu_axi_fetch
//   Instruction fetch unit in front of a single-cycle RV32 core. Owns the
//   fetch PC, issues one AXI4-Lite style read per instruction (at most one
//   outstanding), and hands {inst, inst_pc, inst_fault} to the core over a
//   valid/ready handshake. The core supplies the next PC on every accept;
//   a flush pulse redirects fetch to flush_pc and wins over any other event
//   in the same cycle.
//
// Parameters
//   XLEN      address width (instruction width is fixed at 32)
//   RESET_PC  fetch address after reset
//
// Ports
//   clk         clock
//   reset       asynchronous, active-low reset
//   next_pc     core's next PC, sampled on the accept cycle
//   flush       redirect request (1-cycle pulse)
//   flush_pc    redirect target
//   inst_valid  instruction available to the core
//   inst_ready  core accepts the instruction
//   inst        fetched instruction word (0 when inst_fault is set)
//   inst_pc     address of inst
//   inst_fault  bus error or misaligned PC
//   ar_valid    read address valid
//   ar_ready    read address accepted
//   ar_addr     read address (always the fetch pc)
//   r_valid     read data valid
//   r_ready     read data accepted
//   r_data      read data
//   r_resp      read response (RESP_OKAY or error)
//
// All outputs decode from registered state, so no combinational path exists
// from any input to any output.
// -----------------------------------------------------------------------------
module ifu_axi_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  // core side
  input  logic [XLEN-1:0] next_pc,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  // AXI read address channel
  output logic            ar_valid,
  input  logic            ar_ready,
  output logic [XLEN-1:0] ar_addr,
  // AXI read data channel
  input  logic            r_valid,
  output logic            r_ready,
  input  logic [31:0]     r_data,
  input  logic [1:0]      r_resp
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  // Redirect target remembered while a stale read is still in flight.
  logic [XLEN-1:0] tgt_q, tgt_d;
  // Flush arrived in REQ before the address handshake; go to DROP once the
  // address is accepted instead of to WAIT.
  logic            pend_q, pend_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            fault_q, fault_d;

  // PC load request raised by the state logic; the alignment check below is
  // shared by every path that loads the pc (accept, flush, drained flush).
  logic            load_en;
  logic [XLEN-1:0] load_pc;
  logic            resp_err;

  assign resp_err = (r_resp != RESP_OKAY);

  // ---------------------------------------------------------------------------
  // Next-state and register-update logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    pend_d    = pend_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    fault_d   = fault_q;
    load_en   = 1'b0;
    load_pc   = pc_q;

    case (state_q)
      ST_IDLE: begin
        if (flush) begin
          load_en = 1'b1;
          load_pc = flush_pc;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        // ar_valid is never retracted, so a flush here only records the
        // target; the issued read still has to complete and be drained.
        if (flush) begin
          tgt_d = flush_pc;
          if (ar_ready) begin
            state_d = ST_DROP;
            pend_d  = 1'b0;
          end else begin
            pend_d  = 1'b1;
          end
        end else if (ar_ready) begin
          state_d = pend_q ? ST_DROP : ST_WAIT;
          pend_d  = 1'b0;
        end
      end

      ST_WAIT: begin
        if (flush) begin
          if (r_valid) begin
            // The beat is for the old stream; discard it and redirect now.
            load_en = 1'b1;
            load_pc = flush_pc;
          end else begin
            tgt_d   = flush_pc;
            state_d = ST_DROP;
          end
        end else if (r_valid) begin
          inst_d    = resp_err ? 32'h0 : r_data;
          inst_pc_d = pc_q;
          fault_d   = resp_err;
          state_d   = ST_HOLD;
        end
      end

      ST_HOLD: begin
        // Flush takes precedence over a same-cycle accept.
        if (flush) begin
          load_en = 1'b1;
          load_pc = flush_pc;
        end else if (inst_ready) begin
          load_en = 1'b1;
          load_pc = next_pc;
        end
      end

      ST_DROP: begin
        // Last flush wins: a newer target replaces the remembered one.
        if (r_valid) begin
          load_en = 1'b1;
          load_pc = flush ? flush_pc : tgt_q;
        end else if (flush) begin
          tgt_d = flush_pc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A misaligned pc never reaches the bus: present a fault directly.
    if (load_en) begin
      pc_d = load_pc;
      if (is_misaligned(load_pc[1:0])) begin
        state_d   = ST_HOLD;
        inst_d    = 32'h0;
        inst_pc_d = load_pc;
        fault_d   = 1'b1;
      end else begin
        state_d   = ST_REQ;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  // NOTE: every flop here, datapath included, is on the asynchronous reset so
  // the outputs are defined the moment reset asserts; there is no storage
  // array that would make resetting costly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      tgt_q     <= '0;
      pend_q    <= 1'b0;
      inst_q    <= 32'h0;
      inst_pc_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      pend_q    <= pend_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      fault_q   <= fault_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (decoded from registered state only)
  // ---------------------------------------------------------------------------
  assign ar_valid   = (state_q == ST_REQ);
  assign ar_addr    = pc_q;
  assign r_ready    = (state_q == ST_WAIT) || (state_q == ST_DROP);
  assign inst_valid = (state_q == ST_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = fault_q;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // Address is held stable until accepted.
  a_ar_stable : assert property (@(posedge clk) disable iff (!reset)
    ar_valid && !ar_ready |=> ar_valid && $stable(ar_addr));

  // Only one transaction is ever in flight.
  a_one_outstanding : assert property (@(posedge clk) disable iff (!reset)
    !(ar_valid && r_ready));

  // Presented instruction is stable until accepted or flushed.
  a_inst_stable : assert property (@(posedge clk) disable iff (!reset)
    inst_valid && !inst_ready && !flush |=>
      inst_valid && $stable(inst) && $stable(inst_pc) && $stable(inst_fault));

  // A faulting instruction always reads as zero.
  a_fault_zero : assert property (@(posedge clk) disable iff (!reset)
    inst_valid && inst_fault |-> inst == 32'h0);

endmodule : ifu_axi_fetch

// File: tb/tb_ifu_axi_fetch.sv
// -----------------------------------------------------------------------------
// tb_ifu_axi_fetch
//   Cycle-by-cycle directed vectors for ifu_axi_fetch. Each table row holds
//   the outputs expected in the current cycle and the inputs driven for the
//   following clock edge. Hand-written sequences cover reset, asynchronous
//   reset in the middle of a read, and back-to-back throughput.
// -----------------------------------------------------------------------------
module tb_ifu_axi_fetch;
  import ifu_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] next_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  int n_checks = 0;
  int n_fail   = 0;

  ifu_axi_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .next_pc    (next_pc),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_fault (inst_fault),
    .ar_valid   (ar_valid),
    .ar_ready   (ar_ready),
    .ar_addr    (ar_addr),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_data     (r_data),
    .r_resp     (r_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    // inputs for the coming edge
    logic        ar_ready;
    logic        r_valid;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        inst_ready;
    logic [31:0] next_pc;
    logic        flush;
    logic [31:0] flush_pc;
    // outputs expected this cycle
    logic        e_arv;
    logic [31:0] e_addr;
    logic        e_rr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
    logic        e_fault;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic arr, input logic rv, input logic [31:0] rd, input logic [1:0] rsp,
                     input logic ir, input logic [31:0] npc, input logic fl, input logic [31:0] fpc,
                     input logic earv, input logic [31:0] eaddr, input logic err, input logic eiv,
                     input logic [31:0] einst, input logic [31:0] eipc, input logic ef);
    vec_t v;
    v.ar_ready = arr; v.r_valid = rv; v.r_data = rd; v.r_resp = rsp;
    v.inst_ready = ir; v.next_pc = npc; v.flush = fl; v.flush_pc = fpc;
    v.e_arv = earv; v.e_addr = eaddr; v.e_rr = err; v.e_iv = eiv;
    v.e_inst = einst; v.e_ipc = eipc; v.e_fault = ef;
    tbl.push_back(v);
  endtask

  task automatic drive_idle();
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = RESP_OKAY;
    inst_ready = 0; next_pc = '0; flush = 0; flush_pc = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ar_valid"},   32'(ar_valid),   32'h0);
    check({tag, "_r_ready"},    32'(r_ready),    32'h0);
    check({tag, "_inst_valid"}, 32'(inst_valid), 32'h0);
    check({tag, "_inst_fault"}, 32'(inst_fault), 32'h0);
    check({tag, "_inst"},       inst,            32'h0);
    check({tag, "_inst_pc"},    inst_pc,         32'h0);
    check({tag, "_ar_addr"},    ar_addr,         32'h8000_0000);
  endtask

  initial begin
    //   ar_r rv  r_data        rsp   ir  next_pc       fl  flush_pc       arv addr          rr  iv  inst          inst_pc       flt
    // Normal fetch, accept with next_pc=...04
    add(1, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,        0); // 0 IDLE
    add(1, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0000, 0, 0, 32'h0,        32'h0,        0); // 1 REQ
    add(0, 1, 32'h0000_0413, 2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0,        0); // 2 WAIT
    add(0, 0, 32'h0,        2'b00, 1, 32'h8000_0004, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0000_0413, 32'h8000_0000, 0); // 3 HOLD
    // Back-pressure for five cycles
    add(1, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0004, 0, 0, 32'h0,        32'h0,        0); // 4 REQ
    add(0, 1, 32'h0010_0093, 2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0,        0); // 5 WAIT
    for (int k = 0; k < 5; k++)
      add(0, 0, 32'h0,      2'b00, 0, 32'h8000_0008, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0010_0093, 32'h8000_0004, 0); // 6-10 HOLD stalled
    add(0, 0, 32'h0,        2'b00, 1, 32'h8000_0008, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0010_0093, 32'h8000_0004, 0); // 11 HOLD accept
    // Address held without ar_ready, then bus error
    add(0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0008, 0, 0, 32'h0,        32'h0,        0); // 12 REQ stall
    add(1, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0008, 0, 0, 32'h0,        32'h0,        0); // 13 REQ
    add(0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0,        0); // 14 WAIT
    add(0, 1, 32'hcafe_babe, 2'b10, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0,        0); // 15 WAIT err
    add(0, 0, 32'h0,        2'b00, 1, 32'h8000_000c, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,        32'h8000_0008, 1); // 16 HOLD fault
    // Flush in WAIT, stale beat arrives three cycles later
    add(1, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        1, 32'h8000_000c, 0, 0, 32'h0,        32'h0,        0); // 17 REQ
    add(0, 0, 32'h0,        2'b00, 0, 32'h0,        1, 32'h8000_0100, 0, 32'h0,        1, 0, 32'h0,        32'h0,        0); // 18 WAIT flush
    add(0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0,        0); // 19 DROP
    add(0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0,        0); // 20 DROP
    add(0, 1, 32'hdead_beef, 2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0,        0); // 21 DROP beat
    add(1, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0100, 0, 0, 32'h0,        32'h0,        0); // 22 REQ
    add(0, 1, 32'h0000_0013, 2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0,        0); // 23 WAIT
    // Flush and accept in the same HOLD cycle
    add(0, 0, 32'h0,        2'b00, 1, 32'h8000_0008, 1, 32'h8000_0200, 0, 32'h0,        0, 1, 32'h0000_0013, 32'h8000_0100, 0); // 24 HOLD
    // Flush in REQ without ar_ready: address held, then DROP
    add(0, 0, 32'h0,        2'b00, 0, 32'h0,        1, 32'h8000_0300, 1, 32'h8000_0200, 0, 0, 32'h0,        32'h0,        0); // 25 REQ flush
    add(1, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0200, 0, 0, 32'h0,        32'h0,        0); // 26 REQ held
    add(0, 1, 32'h1111_1111, 2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0,        0); // 27 DROP
    add(1, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0300, 0, 0, 32'h0,        32'h0,        0); // 28 REQ
    add(0, 1, 32'h0020_0113, 2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0,        0); // 29 WAIT
    // Misaligned next_pc: fault without a bus read
    add(0, 0, 32'h0,        2'b00, 1, 32'h8000_0002, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0020_0113, 32'h8000_0300, 0); // 30 HOLD
    add(0, 0, 32'h0,        2'b00, 1, 32'h8000_0010, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,        32'h8000_0002, 1); // 31 HOLD misaligned
    // Flush with same-cycle r_valid in WAIT, flush with same-cycle ar_ready in REQ
    add(1, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0010, 0, 0, 32'h0,        32'h0,        0); // 32 REQ
    add(0, 1, 32'h0bad_f00d, 2'b00, 0, 32'h0,        1, 32'h8000_0400, 0, 32'h0,        1, 0, 32'h0,        32'h0,        0); // 33 WAIT flush+beat
    add(1, 0, 32'h0,        2'b00, 0, 32'h0,        1, 32'h8000_0500, 1, 32'h8000_0400, 0, 0, 32'h0,        32'h0,        0); // 34 REQ flush+ar_ready
    add(0, 1, 32'h2222_2222, 2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0,        0); // 35 DROP
    add(1, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        1, 32'h8000_0500, 0, 0, 32'h0,        32'h0,        0); // 36 REQ
    add(0, 0, 32'h0,        2'b00, 0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0,        0); // 37 WAIT

    // ---------------- reset state ----------------
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #2 reset = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      check($sformatf("row%0d_ar_valid", i),   32'(ar_valid),   32'(tbl[i].e_arv));
      check($sformatf("row%0d_r_ready", i),    32'(r_ready),    32'(tbl[i].e_rr));
      check($sformatf("row%0d_inst_valid", i), 32'(inst_valid), 32'(tbl[i].e_iv));
      if (tbl[i].e_arv)
        check($sformatf("row%0d_ar_addr", i), ar_addr, tbl[i].e_addr);
      if (tbl[i].e_iv) begin
        check($sformatf("row%0d_inst", i),       inst,             tbl[i].e_inst);
        check($sformatf("row%0d_inst_pc", i),    inst_pc,          tbl[i].e_ipc);
        check($sformatf("row%0d_inst_fault", i), 32'(inst_fault),  32'(tbl[i].e_fault));
      end
      ar_ready   = tbl[i].ar_ready;
      r_valid    = tbl[i].r_valid;
      r_data     = tbl[i].r_data;
      r_resp     = tbl[i].r_resp;
      inst_ready = tbl[i].inst_ready;
      next_pc    = tbl[i].next_pc;
      flush      = tbl[i].flush;
      flush_pc   = tbl[i].flush_pc;
    end

    // ---------------- asynchronous reset mid-WAIT ----------------
    @(negedge clk);
    drive_idle();
    check("midwait_r_ready", 32'(r_ready), 32'h1);
    #2 reset = 1'b0;
    #1 check_reset_outputs("async_reset");

    // ---------------- back-to-back throughput ----------------
    @(posedge clk);
    #2 reset = 1'b1;
    begin
      logic        seen;
      logic [31:0] fa;
      int          n_ar;
      int          n_iv;
      seen = 1'b0;
      fa   = 32'h8000_0000;
      n_ar = 0;
      n_iv = 0;
      for (int w = 0; w < 5 && !seen; w++) begin
        @(negedge clk);
        seen = ar_valid;
      end
      check("tp_first_ar_valid", 32'(seen), 32'h1);
      for (int c = 0; c < 12; c++) begin
        if (c > 0) @(negedge clk);
        if (ar_valid) begin
          n_ar++;
          check($sformatf("tp_ar_addr%0d", n_ar), ar_addr, fa);
        end
        if (inst_valid) begin
          n_iv++;
          check($sformatf("tp_inst_pc%0d", n_iv), inst_pc, fa);
          check($sformatf("tp_inst%0d", n_iv), inst, 32'h0000_0013);
          fa = fa + 32'd4;
        end
        ar_ready   = 1'b1;
        r_valid    = 1'b1;
        r_data     = 32'h0000_0013;
        r_resp     = RESP_OKAY;
        inst_ready = 1'b1;
        next_pc    = fa;
      end
      check("tp_ar_count", 32'(n_ar), 32'd4);
      check("tp_iv_count", 32'(n_iv), 32'd4);
    end

    drive_idle();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ifu_axi_fetch
